// File: rtl/jtag_mem_master.sv
// Debug-side RAM initiator: byte/half/word accesses over the RAM JTAG port, with writes held off while the LSU writes.
// Optional post-increment addressing is compiled in when JTAG_MEM_AUTOINC_EN is defined.
module jtag_mem_master #(
    parameter int ADDR_W      = 32,
    parameter int HOLDOFF_MAX = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [1:0]        cmd_size_i,
    input  logic              cmd_incr_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [31:0]       cmd_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    input  logic              lsu_wr_busy_i,
    output logic              jtag_ce_o,
    output logic              jtag_we_o,
    output logic [3:0]        jtag_sel_o,
    output logic [ADDR_W-1:0] jtag_addr_o,
    output logic [31:0]       jtag_data_o,
    input  logic              jtag_rvalid_i,
    input  logic [31:0]       jtag_data_i
);

    localparam int CNT_W = $clog2(HOLDOFF_MAX + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state, state_nxt;
    logic              we_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic [ADDR_W-1:0] cmd_addr_sel;
    logic              accept;
    logic              bad_align;
    logic              active;
    logic              expire;

    function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    lane_sel = 4'b0001 << off;
            2'd1:    lane_sel = 4'b0011 << off;
            default: lane_sel = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] data);
        case (size)
            2'd0:    lane_wdata = {4{data[7:0]}};
            2'd1:    lane_wdata = {2{data[15:0]}};
            default: lane_wdata = data;
        endcase
    endfunction

    function automatic logic [31:0] lane_rdata(input logic [1:0] size, input logic [1:0] off,
                                               input logic [31:0] word);
        logic [31:0] shifted;
        shifted = word >> {off, 3'b000};
        case (size)
            2'd0:    lane_rdata = {24'd0, shifted[7:0]};
            2'd1:    lane_rdata = {16'd0, shifted[15:0]};
            default: lane_rdata = shifted;
        endcase
    endfunction

`ifdef JTAG_MEM_AUTOINC_EN
    logic [ADDR_W-1:0] next_addr;
    logic              step;

    // Advance only on an access that actually reached the RAM without error.
    assign step         = (state == ACCESS) && !rst_i && (we_q ? !lsu_wr_busy_i : jtag_rvalid_i);
    assign cmd_addr_sel = cmd_incr_i ? next_addr : cmd_addr_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            next_addr <= '0;
        end else if (step) begin
            next_addr <= addr_q + (ADDR_W'(1) << size_q);
        end
    end
`else
    logic unused_incr;
    assign unused_incr  = cmd_incr_i;
    assign cmd_addr_sel = cmd_addr_i;
`endif

    assign bad_align = (cmd_size_i == 2'd3) ||
                       ((cmd_size_i == 2'd1) && cmd_addr_sel[0]) ||
                       ((cmd_size_i == 2'd2) && (cmd_addr_sel[1:0] != 2'b00));
    assign accept    = cmd_ready_o && cmd_valid_i;
    assign active    = (state == ACCESS) && !rst_i;

    always_comb begin
        state_nxt   = state;
        cmd_ready_o = 1'b0;
        jtag_ce_o   = 1'b0;
        jtag_we_o   = 1'b0;
        expire      = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready_o = !rst_i;
                if (cmd_valid_i) begin
                    state_nxt = bad_align ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    // The RAM drops a JTAG write that collides with an LSU write, so wait it out.
                    if (lsu_wr_busy_i) begin
                        expire = (wait_cnt == CNT_W'(HOLDOFF_MAX - 1));
                        if (expire) begin
                            state_nxt = RESP;
                        end
                    end else begin
                        jtag_ce_o = !rst_i;
                        jtag_we_o = !rst_i;
                        state_nxt = RESP;
                    end
                end else begin
                    jtag_ce_o = !rst_i;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            wait_cnt <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                wait_cnt <= '0;
                rdata_q  <= '0;
                err_q    <= bad_align;
            end else if (state == ACCESS) begin
                if (we_q) begin
                    if (lsu_wr_busy_i) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                        err_q    <= expire;
                    end
                end else begin
                    rdata_q <= jtag_rvalid_i ? lane_rdata(size_q, addr_q[1:0], jtag_data_i) : '0;
                    err_q   <= !jtag_rvalid_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            we_q    <= cmd_we_i;
            size_q  <= cmd_size_i;
            addr_q  <= cmd_addr_sel;
            wdata_q <= cmd_wdata_i;
        end
    end

    assign jtag_sel_o  = active ? lane_sel(size_q, addr_q[1:0]) : 4'b0000;
    assign jtag_addr_o = active ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign jtag_data_o = active ? lane_wdata(size_q, wdata_q) : 32'd0;
    assign rsp_valid_o = (state == RESP) && !rst_i;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule
